matrix_c_drain: RTL
===================

// Module: matrix_c_drain
// PURPOSE
//  Reader side of the MatrixMulEngine result buffer. On the engine's done rising edge, reads
//  the row-major flattened C matrix (M x N IEEE-754 fp32 words) through a 1-cycle-latency read port.
//  Emits C as a valid/ready stream, one word per beat, tagged with row/col and a last flag.
//  Sits between MatrixMulEngine and the host/DMA egress path; replaces bench-side polling of C.
// PARAMETERS
//  DATA_W  32   element width (fp32 bit pattern, passed through untouched)
//  MAX_M   100  max rows of C accepted
//  MAX_N   100  max cols of C accepted
//  ADDR_W  14   C read address width; must satisfy 2**ADDR_W >= MAX_M*MAX_N
// PORTS
//  clk         in   1       single clock, all logic on rising edge
//  rst         in   1       asynchronous, active-high reset
//  M_val       in   8       rows of C; sampled with done_in rising edge
//  N_val       in   8       cols of C; sampled with done_in rising edge
//  done_in     in   1       engine done (level); rising edge starts a drain
//  c_rd_en     out  1       C read strobe
//  c_rd_addr   out  ADDR_W  C word address = row*N + col
//  c_rd_data   in   DATA_W  C read data, valid the cycle after c_rd_en
//  m_valid     out  1       stream beat valid
//  m_ready     in   1       stream sink ready
//  m_data      out  DATA_W  C element
//  m_row       out  8       row index of m_data
//  m_col       out  8       col index of m_data
//  m_last      out  1       high on element (M-1, N-1) only
//  busy        out  1       high from accepted start until final handshake
//  drain_done  out  1       1-cycle pulse after final handshake
//  err         out  1       1-cycle pulse on illegal size; no drain performed
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, output buffer empty. Async assert, sync deassert use.
//  FSM IDLE -> RUN -> IDLE. Start = done_in high at an edge where it was low at the previous edge.
//  IDLE + start: latch M_val/N_val. If M==0, N==0, M>MAX_M or N>MAX_N: pulse err, stay IDLE.
//   Otherwise enter RUN, busy=1.
//  RUN: read counters (rr,rc) walk row-major; c_rd_addr = rr*N + rc (ADDR_W-bit, no overflow by param rule).
//   c_rd_en issued only while (buffered + in-flight) < 2. A 2-entry output FIFO holds the row/col tags.
//  Latency: first c_rd_en in the cycle after the start edge; first m_valid one cycle later.
//  Throughput: 1 beat/cycle sustained while m_ready=1.
//  Handshake: beat transfers when m_valid & m_ready. While m_valid & !m_ready, m_data/m_row/m_col/m_last
//   are held stable. m_valid never drops without a transfer. No reads are issued once all M*N words are read.
//  Final handshake (m_last beat): drain_done pulses next cycle, busy=0, FSM returns to IDLE.
//  Start edges seen while in RUN are ignored; they neither restart nor queue a drain.
//   A done_in held high after the drain does not retrigger.
//  rst mid-drain: immediate abort, FIFO flushed, outputs 0. A new drain requires a fresh done_in rising edge.
//  1x1 matrix: a single beat, with m_last=1.
// TESTING
//  T1 M=2,N=2, C={3f800000,40000000,40400000,40800000}, m_ready=1 -> 4 beats on consecutive cycles;
//     (row,col)=(0,0),(0,1),(1,0),(1,1); m_last on beat 4; drain_done 1 cycle after.
//  T2 M=3,N=5, m_ready random 50% -> 15 beats in address order 0..14; data held while stalled;
//     no more than 2 reads outstanding.
//  T3 M=0,N=4 start -> err pulse for 1 cycle; c_rd_en, busy and m_valid stay 0.
//     Repeat with M=101 -> same result.
//  T4 M=100,N=100, m_ready=1 -> 10000 beats, last c_rd_addr=9999, last beat (99,99) with m_last;
//     total busy = 10001 cycles +/- 1.
//  T5 M=4,N=4; assert rst after beat 5 -> outputs 0 same cycle.
//     Rerun with a new done_in edge -> full 16 beats from (0,0).
//  T6 M=2,N=3; toggle done_in 0->1 during RUN, and hold done_in=1 after the drain -> exactly 6 beats, one drain_done.

Source files
------------

// File: rtl/matrix_c_drain_if.sv
// matrix_c_drain_if: size/start inputs, C read port and result stream of the C drain.
interface matrix_c_drain_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic [7:0]        M_val;
  logic [7:0]        N_val;
  logic              done_in;
  logic              c_rd_en;
  logic [ADDR_W-1:0] c_rd_addr;
  logic [DATA_W-1:0] c_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [7:0]        m_row;
  logic [7:0]        m_col;
  logic              m_last;
  logic              busy;
  logic              drain_done;
  logic              err;
  modport master (
    input  M_val, N_val, done_in, c_rd_data, m_ready,
    output c_rd_en, c_rd_addr, m_valid, m_data, m_row, m_col, m_last, busy, drain_done, err
  );
  modport slave (
    output M_val, N_val, done_in, c_rd_data, m_ready,
    input  c_rd_en, c_rd_addr, m_valid, m_data, m_row, m_col, m_last, busy, drain_done, err
  );
endinterface

// File: rtl/matrix_c_drain.sv
// matrix_c_drain: on a done_in rising edge, reads the M x N C buffer row-major and streams it out.
module matrix_c_drain #(
  parameter int DATA_W = 32,
  parameter int MAX_M  = 100,
  parameter int MAX_N  = 100,
  parameter int ADDR_W = 14
) (
  input logic             clk,
  input logic             rst,
  matrix_c_drain_if.master bus
);
  typedef enum logic {IDLE, RUN} st_e;
  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       last;
  } tag_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } ent_t;
  st_e               st_q, st_d;
  logic              done_prev_q, done_prev_d;
  logic [7:0]        m_q, m_d, n_q, n_d, rr_q, rr_d, rc_q, rc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_all_q, rd_all_d, infl_q, infl_d;
  tag_t              pend_q, pend_d, tag_now;
  ent_t              f0_q, f0_d, f1_q, f1_d, incoming, head;
  logic [1:0]        cnt_q, cnt_d, keep;
  logic              err_q, err_d, dd_q, dd_d;
  logic              start, bad, valid, pop, fin, issue, push;
  logic [2:0]        occ;
  assign start    = bus.done_in & ~done_prev_q;
  assign bad      = bus.M_val == 8'd0 || bus.N_val == 8'd0 ||
                    bus.M_val > 8'(MAX_M) || bus.N_val > 8'(MAX_N);
  assign incoming = {bus.c_rd_data, pend_q};
  assign head     = cnt_q != 2'd0 ? f0_q : incoming;
  assign valid    = cnt_q != 2'd0 || infl_q;
  assign pop      = valid & bus.m_ready;
  assign fin      = pop & head.tag.last;
  // Credit the beat leaving this cycle so a full pipeline still issues one read per cycle.
  assign occ      = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
  assign issue    = st_q == RUN && !rd_all_q && occ < 3'd2;
  assign tag_now  = '{row: rr_q, col: rc_q,
                      last: rr_q == m_q - 8'd1 && rc_q == n_q - 8'd1};
  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  always_comb
    st_d = st_q == IDLE ? ((start && !bad) ? RUN : IDLE) : (fin ? IDLE : RUN);
  always_comb begin
    m_d         = m_q;
    n_d         = n_q;
    rr_d        = rr_q;
    rc_d        = rc_q;
    addr_d      = addr_q;
    rd_all_d    = rd_all_q;
    pend_d      = pend_q;
    infl_d      = issue;
    done_prev_d = bus.done_in;
    err_d       = st_q == IDLE && start && bad;
    dd_d        = fin;
    if (st_q == IDLE && start) begin
      m_d      = bus.M_val;
      n_d      = bus.N_val;
      rr_d     = 8'd0;
      rc_d     = 8'd0;
      addr_d   = '0;
      rd_all_d = 1'b0;
    end
    if (issue) begin
      pend_d   = tag_now;
      addr_d   = addr_q + 1'b1;
      rc_d     = rc_q == n_q - 8'd1 ? 8'd0 : rc_q + 8'd1;
      rr_d     = rc_q == n_q - 8'd1 ? rr_q + 8'd1 : rr_q;
      rd_all_d = tag_now.last;
    end
    // Arriving read data bypasses the FIFO when it is consumed the same cycle it lands.
    f0_d = f0_q;
    f1_d = f1_q;
    keep = cnt_q - {1'b0, pop && cnt_q != 2'd0};
    push = infl_q && !(pop && cnt_q == 2'd0);
    if (pop && cnt_q != 2'd0) f0_d = f1_q;
    if (push && keep == 2'd0) f0_d = incoming;
    if (push && keep != 2'd0) f1_d = incoming;
    cnt_d = keep + {1'b0, push};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done_prev_q <= 1'b1;
      m_q         <= '0;
      n_q         <= '0;
      rr_q        <= '0;
      rc_q        <= '0;
      addr_q      <= '0;
      rd_all_q    <= 1'b0;
      infl_q      <= 1'b0;
      pend_q      <= '0;
      f0_q        <= '0;
      f1_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      dd_q        <= 1'b0;
    end else begin
      done_prev_q <= done_prev_d;
      m_q         <= m_d;
      n_q         <= n_d;
      rr_q        <= rr_d;
      rc_q        <= rc_d;
      addr_q      <= addr_d;
      rd_all_q    <= rd_all_d;
      infl_q      <= infl_d;
      pend_q      <= pend_d;
      f0_q        <= f0_d;
      f1_q        <= f1_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      dd_q        <= dd_d;
    end
  always_comb begin
    bus.busy       = st_q == RUN;
    bus.c_rd_en    = issue;
    bus.c_rd_addr  = issue ? addr_q : '0;
    bus.m_valid    = valid;
    bus.m_data     = valid ? head.data : '0;
    bus.m_row      = valid ? head.tag.row : 8'd0;
    bus.m_col      = valid ? head.tag.col : 8'd0;
    bus.m_last     = valid & head.tag.last;
    bus.drain_done = dd_q;
    bus.err        = err_q;
  end
endmodule
